i2s_rx: RTL and testbench

- I2S receiver: the receive-side counterpart of the `i2s` transmitter.
- Samples an external I2S bit stream (`i2s_sclk`, `i2s_ws`, `i2s_sd`) in the system `clk` domain and recovers each stereo frame.
- Presents the left and right samples in parallel with a one-cycle `sample_valid` strobe.
- Uses: capturing an external ADC/line-in, and loopback self-check of the `i2s` transmitter output.

---
 rtl/opl3_pkg.sv | 14 +
 rtl/synchronizer.sv | 30 +++
 rtl/i2s_rx.sv | 183 ++++++++++++++++++
 tb/tb_i2s_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 audio path.
//   DAC_OUTPUT_WIDTH : single sample-width constant used by the DAC/I2S blocks
//   i2s_rx_state_t   : framing states of the I2S receiver (HUNT, LEFT, RIGHT)
package opl3_pkg;

    localparam int DAC_OUTPUT_WIDTH = 16;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_rx_state_t;

endpackage

// File: rtl/synchronizer.sv
// Multi-stage flip-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk     : destination clock
//   reset_n : asynchronous active-low reset, clears every stage to 0
//   d       : asynchronous input
//   q       : synchronized output (STAGES clk cycles of latency)
// STAGES must be at least 2.
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the input through the synchronizer chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: samples an external I2S stream in the clk domain and
// delivers each stereo frame as a left/right pair with a one-cycle strobe.
// Ports:
//   clk, reset_n    : system clock, asynchronous active-low reset
//   i2s_sclk        : external bit clock (asynchronous)
//   i2s_ws          : word select, 0 = left, 1 = right (asynchronous)
//   i2s_sd          : serial data, MSB first (asynchronous)
//   left_channel    : last complete left sample
//   right_channel   : last complete right sample
//   sample_valid    : one-cycle pulse, channel outputs updated in that cycle
//   frame_error     : one-cycle pulse, a slot shorter than SAMPLE_WIDTH ended
import opl3_pkg::*;

module i2s_rx #(
    parameter int SAMPLE_WIDTH   = DAC_OUTPUT_WIDTH,
    parameter int SLOT_CNT_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i2s_sclk,
    input  logic                    i2s_ws,
    input  logic                    i2s_sd,
    output logic [SAMPLE_WIDTH-1:0] left_channel,
    output logic [SAMPLE_WIDTH-1:0] right_channel,
    output logic                    sample_valid,
    output logic                    frame_error
);

    // One extra bit so bit_cnt+1 never wraps when the counter is saturated.
    localparam int                      CW      = SLOT_CNT_WIDTH + 1;
    localparam logic [CW-1:0]           SW_EXT  = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0]           EXT_ONE = CW'(1);
    localparam logic [SLOT_CNT_WIDTH-1:0] CNT_MAX = {SLOT_CNT_WIDTH{1'b1}};
    localparam logic [SLOT_CNT_WIDTH-1:0] CNT_ONE = SLOT_CNT_WIDTH'(1);

    // Move a short word (n bits in the LSBs) to the MSBs, zero-filling below.
    function automatic logic [SAMPLE_WIDTH-1:0] left_justify(
        input logic [SAMPLE_WIDTH-1:0] w,
        input logic [CW-1:0]           n
    );
        return w << (SW_EXT - n);
    endfunction

    logic sclk_s, ws_s, sd_s;

    synchronizer #(.STAGES(2)) u_sync_sclk (.clk(clk), .reset_n(reset_n), .d(i2s_sclk), .q(sclk_s));
    synchronizer #(.STAGES(2)) u_sync_ws   (.clk(clk), .reset_n(reset_n), .d(i2s_ws),   .q(ws_s));
    synchronizer #(.STAGES(2)) u_sync_sd   (.clk(clk), .reset_n(reset_n), .d(i2s_sd),   .q(sd_s));

    logic                      sclk_prev_r, bit_event_r, ws_bit_r, sd_bit_r;
    i2s_rx_state_t             state_r, state_nxt_s;
    logic                      ws_q_r, ws_q_nxt_s;
    logic [SLOT_CNT_WIDTH-1:0] bit_cnt_r, bit_cnt_nxt_s;
    logic [SAMPLE_WIDTH-1:0]   shift_r, shift_nxt_s;
    logic [SAMPLE_WIDTH-1:0]   left_hold_r, left_hold_nxt_s;
    logic                      left_full_r, left_full_nxt_s;
    logic [SAMPLE_WIDTH-1:0]   left_nxt_s, right_nxt_s;
    logic                      valid_nxt_s, ferr_nxt_s;
    logic [SAMPLE_WIDTH-1:0]   shifted_s, word_s;
    logic [CW-1:0]             cnt_inc_s;
    logic                      short_s;

    // Rising-edge detect on sclk; ws/sd are re-registered to line up with the event.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_prev_r <= 1'b0;
            bit_event_r <= 1'b0;
            ws_bit_r    <= 1'b0;
            sd_bit_r    <= 1'b0;
        end else begin
            sclk_prev_r <= sclk_s;
            bit_event_r <= sclk_s & ~sclk_prev_r;
            ws_bit_r    <= ws_s;
            sd_bit_r    <= sd_s;
        end
    end

    // Framing state, slot capture registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= HUNT;
            ws_q_r        <= 1'b0;
            bit_cnt_r     <= {SLOT_CNT_WIDTH{1'b0}};
            shift_r       <= {SAMPLE_WIDTH{1'b0}};
            left_hold_r   <= {SAMPLE_WIDTH{1'b0}};
            left_full_r   <= 1'b0;
            left_channel  <= {SAMPLE_WIDTH{1'b0}};
            right_channel <= {SAMPLE_WIDTH{1'b0}};
            sample_valid  <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            ws_q_r        <= ws_q_nxt_s;
            bit_cnt_r     <= bit_cnt_nxt_s;
            shift_r       <= shift_nxt_s;
            left_hold_r   <= left_hold_nxt_s;
            left_full_r   <= left_full_nxt_s;
            left_channel  <= left_nxt_s;
            right_channel <= right_nxt_s;
            sample_valid  <= valid_nxt_s;
            frame_error   <= ferr_nxt_s;
        end
    end

    // Per-bit shifting, slot-end word assembly and state transitions.
    always_comb begin
        state_nxt_s     = state_r;
        ws_q_nxt_s      = ws_q_r;
        bit_cnt_nxt_s   = bit_cnt_r;
        shift_nxt_s     = shift_r;
        left_hold_nxt_s = left_hold_r;
        left_full_nxt_s = left_full_r;
        left_nxt_s      = left_channel;
        right_nxt_s     = right_channel;
        valid_nxt_s     = 1'b0;
        ferr_nxt_s      = 1'b0;

        // Bits beyond SAMPLE_WIDTH are dropped but still counted.
        if ({1'b0, bit_cnt_r} < SW_EXT) begin
            shifted_s = {shift_r[SAMPLE_WIDTH-2:0], sd_bit_r};
        end else begin
            shifted_s = shift_r;
        end

        cnt_inc_s = {1'b0, bit_cnt_r} + EXT_ONE;
        short_s   = (cnt_inc_s < SW_EXT);
        if (short_s) begin
            word_s = left_justify(shifted_s, cnt_inc_s);
        end else begin
            word_s = shifted_s;
        end

        if (bit_event_r) begin
            ws_q_nxt_s = ws_bit_r;
            if (ws_bit_r != ws_q_r) begin
                // The bit just sampled is the LSB of the slot that ends here.
                bit_cnt_nxt_s = {SLOT_CNT_WIDTH{1'b0}};
                shift_nxt_s   = {SAMPLE_WIDTH{1'b0}};
                case (state_r)
                    HUNT: begin
                        if (ws_bit_r) begin
                            state_nxt_s = RIGHT;
                        end else begin
                            state_nxt_s = LEFT;
                        end
                    end
                    LEFT: begin
                        left_hold_nxt_s = word_s;
                        left_full_nxt_s = 1'b1;
                        ferr_nxt_s      = short_s;
                        state_nxt_s     = RIGHT;
                    end
                    RIGHT: begin
                        // A right slot with no stored left half is dropped silently.
                        if (left_full_r) begin
                            left_nxt_s      = left_hold_r;
                            right_nxt_s     = word_s;
                            valid_nxt_s     = 1'b1;
                            ferr_nxt_s      = short_s;
                            left_full_nxt_s = 1'b0;
                        end else begin
                            valid_nxt_s = 1'b0;
                        end
                        state_nxt_s = LEFT;
                    end
                    default: begin
                        state_nxt_s = HUNT;
                    end
                endcase
            end else begin
                shift_nxt_s = shifted_s;
                if (bit_cnt_r != CNT_MAX) begin
                    bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r;
                end
            end
        end else begin
            ws_q_nxt_s = ws_q_r;
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: drives an I2S bit stream (sclk = clk/8) and
// checks each recovered frame against hand-computed values.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i2s_sclk = 1'b0;
    logic        i2s_ws = 1'b0;
    logic        i2s_sd = 1'b0;
    logic [15:0] left_channel, right_channel;
    logic        sample_valid, frame_error;

    always #5 clk = ~clk;

    i2s_rx #(.SAMPLE_WIDTH(16), .SLOT_CNT_WIDTH(6)) dut (
        .clk(clk), .reset_n(reset_n),
        .i2s_sclk(i2s_sclk), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
        .left_channel(left_channel), .right_channel(right_channel),
        .sample_valid(sample_valid), .frame_error(frame_error)
    );

    int total = 0;
    int bad = 0;

    // Pulse monitor, sampled away from the active edge.
    int          valid_cnt = 0;
    int          ferr_cnt = 0;
    logic [15:0] cap_l = 16'h0000;
    logic [15:0] cap_r = 16'h0000;
    logic        cap_fv = 1'b0;

    always @(negedge clk) begin
        if (sample_valid) begin
            valid_cnt = valid_cnt + 1;
            cap_l  = left_channel;
            cap_r  = right_channel;
            cap_fv = frame_error;
        end
        if (frame_error) ferr_cnt = ferr_cnt + 1;
    end

    typedef struct {
        int          len_l;
        logic [31:0] wl;
        int          len_r;
        logic [31:0] wr;
        logic [15:0] el;
        logic [15:0] er;
        logic        ef_v;
        int          ef_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One I2S bit: data/ws change while sclk is low, receiver samples on the rise.
    task automatic send_bit(input logic ws, input logic sd);
        i2s_ws = ws;
        i2s_sd = sd;
        #40;
        i2s_sclk = 1'b1;
        #40;
        i2s_sclk = 1'b0;
    endtask

    // A slot of n bits, MSB first; ws flips on the LSB (one bit before the next MSB).
    task automatic send_slot(input int n, input logic [31:0] w, input logic ws_cur, input logic ws_next);
        for (int j = 0; j < n; j++) begin
            send_bit((j == n - 1) ? ws_next : ws_cur, w[n-1-j]);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    int          v0, f0;
    logic [15:0] hw;
    logic [15:0] diff;
    logic [15:0] rw;

    initial begin
        vecs[0] = '{16, 32'h1234,   16, 32'h8000,   16'h1234, 16'h8000, 1'b0, 0};
        vecs[1] = '{16, 32'h0000,   16, 32'hFFFF,   16'h0000, 16'hFFFF, 1'b0, 0};
        vecs[2] = '{24, 32'hABCDEF, 24, 32'h123456, 16'hABCD, 16'h1234, 1'b0, 0};
        vecs[3] = '{16, 32'hA5A5,   12, 32'hFFF,    16'hA5A5, 16'hFFF0, 1'b1, 1};
        vecs[4] = '{8,  32'hC3,     16, 32'h5A5A,   16'hC300, 16'h5A5A, 1'b0, 1};
        vecs[5] = '{16, 32'h7FFF,   16, 32'h0001,   16'h7FFF, 16'h0001, 1'b0, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_left", {16'h0, left_channel}, 32'h0);
        check("rst_right", {16'h0, right_channel}, 32'h0);
        check("rst_valid", {31'h0, sample_valid}, 32'h0);
        check("rst_ferr", {31'h0, frame_error}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Priming frame: consumed by hunting, never delivered
        v0 = valid_cnt;
        send_slot(16, 32'h1111, 1'b0, 1'b1);
        send_slot(16, 32'h2222, 1'b1, 1'b0);
        settle();
        check("prime_valid", valid_cnt - v0, 32'd0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_slot(vecs[i].len_l, vecs[i].wl, 1'b0, 1'b1);
            send_slot(vecs[i].len_r, vecs[i].wr, 1'b1, 1'b0);
            settle();
            check($sformatf("v%0d_valid", i), valid_cnt - v0, 32'd1);
            check($sformatf("v%0d_left", i), {16'h0, cap_l}, {16'h0, vecs[i].el});
            check($sformatf("v%0d_right", i), {16'h0, cap_r}, {16'h0, vecs[i].er});
            check($sformatf("v%0d_ferr_with_valid", i), {31'h0, cap_fv}, {31'h0, vecs[i].ef_v});
            check($sformatf("v%0d_ferr_count", i), ferr_cnt - f0, vecs[i].ef_cnt);
        end

        // Counting stream, as a transmitter loopback would produce
        for (int i = 0; i < 4; i++) begin
            rw = 16'h8000 + 16'(i);
            v0 = valid_cnt;
            send_slot(16, 32'(i), 1'b0, 1'b1);
            send_slot(16, {16'h0, rw}, 1'b1, 1'b0);
            settle();
            diff = cap_r - cap_l;
            check($sformatf("loop%0d_valid", i), valid_cnt - v0, 32'd1);
            check($sformatf("loop%0d_diff", i), {16'h0, diff}, 32'h8000);
            check($sformatf("loop%0d_left", i), {16'h0, cap_l}, 32'(i));
        end

        // Held WS: a 70-bit left slot saturates the counter without pulses
        hw = 16'hBEEF;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        for (int j = 0; j < 69; j++) begin
            send_bit(1'b0, (j < 16) ? hw[15-j] : 1'b0);
        end
        settle();
        check("held_no_valid", valid_cnt - v0, 32'd0);
        check("held_no_ferr", ferr_cnt - f0, 32'd0);
        send_bit(1'b1, 1'b0);
        send_slot(16, 32'h0F0F, 1'b1, 1'b0);
        settle();
        check("held_valid", valid_cnt - v0, 32'd1);
        check("held_left", {16'h0, cap_l}, 32'hBEEF);
        check("held_right", {16'h0, cap_r}, 32'h0F0F);
        check("held_ferr", ferr_cnt - f0, 32'd0);

        // Reset in the middle of a left slot
        hw = 16'h5555;
        for (int j = 0; j < 5; j++) send_bit(1'b0, hw[15-j]);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_left", {16'h0, left_channel}, 32'h0);
        check("midrst_right", {16'h0, right_channel}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        v0 = valid_cnt;
        for (int j = 5; j < 16; j++) send_bit((j == 15) ? 1'b1 : 1'b0, hw[15-j]);
        send_slot(16, 32'h6666, 1'b1, 1'b0);
        settle();
        check("midrst_rehunt_no_valid", valid_cnt - v0, 32'd0);
        send_slot(16, 32'h1357, 1'b0, 1'b1);
        send_slot(16, 32'h2468, 1'b1, 1'b0);
        settle();
        check("midrst_valid", valid_cnt - v0, 32'd1);
        check("midrst_left_after", {16'h0, cap_l}, 32'h1357);
        check("midrst_right_after", {16'h0, cap_r}, 32'h2468);

        // Startup in the middle of a right slot
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        v0 = valid_cnt;
        for (int j = 0; j < 7; j++) send_bit((j == 6) ? 1'b0 : 1'b1, j[0]);
        send_slot(16, 32'h0A0A, 1'b0, 1'b1);
        settle();
        check("start_no_valid_after_left", valid_cnt - v0, 32'd0);
        send_slot(16, 32'hB0B0, 1'b1, 1'b0);
        settle();
        check("start_valid", valid_cnt - v0, 32'd1);
        check("start_left", {16'h0, cap_l}, 32'h0A0A);
        check("start_right", {16'h0, cap_r}, 32'hB0B0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
